sdram_arbiter: RTL and testbench



---
 rtl/sdram_arb_pkg.sv | 19 +
 rtl/sdram_arbiter_if.sv | 46 ++++
 rtl/sdram_arb_pick.sv | 28 ++
 rtl/sdram_arbiter.sv | 138 +++++++++++++
 tb/tb_sdram_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and sizing helpers for the two-port SDRAM burst arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StBurst,
    StDrain
  } arb_state_e;

  localparam int unsigned MaxBurstLength = 8;
  // One spare bit so a full burst count never wraps.
  localparam int unsigned BeatCntWidth   = $clog2(MaxBurstLength) + 1;

  function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester, controller and status signals of the SDRAM arbiter, bundled.
interface sdram_arbiter_if #(
  parameter int unsigned AddressWidth = 24,
  parameter int unsigned WordLength   = 16
);
  logic                    p0_req;
  logic                    p1_req;
  logic                    p0_rw;
  logic                    p1_rw;
  logic [AddressWidth-1:0] p0_addr;
  logic [AddressWidth-1:0] p1_addr;
  logic [WordLength-1:0]   p0_wdata;
  logic [WordLength-1:0]   p1_wdata;
  logic                    p0_ack;
  logic                    p1_ack;
  logic                    p0_wr_beat;
  logic                    p1_wr_beat;
  logic                    p0_rd_beat;
  logic                    p1_rd_beat;
  logic [WordLength-1:0]   p0_rdata;
  logic [WordLength-1:0]   p1_rdata;
  logic                    m_enable;
  logic                    m_rw;
  logic [AddressWidth-1:0] m_addr;
  logic [WordLength-1:0]   m_wdata;
  logic [WordLength-1:0]   m_rdata;
  logic                    m_valid_wr;
  logic                    m_valid_rd;
  logic                    m_busy;
  logic                    o_owner;
  logic                    o_err;

  modport slave (
    input  p0_req, p1_req, p0_rw, p1_rw, p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  m_rdata, m_valid_wr, m_valid_rd, m_busy,
    output p0_ack, p1_ack, p0_wr_beat, p1_wr_beat, p0_rd_beat, p1_rd_beat,
    output p0_rdata, p1_rdata, m_enable, m_rw, m_addr, m_wdata, o_owner, o_err
  );

  modport master (
    output p0_req, p1_req, p0_rw, p1_rw, p0_addr, p1_addr, p0_wdata, p1_wdata,
    output m_rdata, m_valid_wr, m_valid_rd, m_busy,
    input  p0_ack, p1_ack, p0_wr_beat, p1_wr_beat, p0_rd_beat, p1_rd_beat,
    input  p0_rdata, p1_rdata, m_enable, m_rw, m_addr, m_wdata, o_owner, o_err
  );
endinterface

// File: rtl/sdram_arb_pick.sv
// Combinational winner select. SDRAM_ARB_FIXED_PRIO_EN gives port 0 every tie;
// otherwise ties go to the port that did not own the last burst.
module sdram_arb_pick (
  input  logic p0_req,
  input  logic p1_req,
  input  logic owner,
  output logic grant_valid,
  output logic grant
);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  logic unused_owner;
  assign unused_owner = owner;
`endif

  always_comb begin
    grant_valid = p0_req | p1_req;
    grant       = p1_req;
    if (p0_req && p1_req) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~owner;
`endif
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port burst arbiter in front of the SDRAM controller (port 0 VGA, port 1 UART).
// Tie policy selectable with SDRAM_ARB_FIXED_PRIO_EN (see sdram_arb_pick).
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned AddressWidth  = 24,
  parameter int unsigned WordLength    = 16,
  parameter int unsigned BurstLength   = 8,
  parameter int unsigned TimeoutCycles = 1024
) (
  input logic            CLK,
  input logic            RST,
  sdram_arbiter_if.slave bus
);

  localparam int unsigned TmoWidth = tmo_cnt_width(TimeoutCycles);
  localparam logic [BeatCntWidth-1:0] BeatLast = BeatCntWidth'(BurstLength - 1);
  // tmo_q lags cycles-since-enable by one; leaving here lands IDLE and o_err
  // exactly TimeoutCycles after the ISSUE cycle.
  localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TimeoutCycles - 2);

  arb_state_e              state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    rw_q, rw_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [BeatCntWidth-1:0] beat_cnt_q, beat_cnt_d;
  logic [TmoWidth-1:0]     tmo_q, tmo_d;
  logic                    err_q, err_d;
  logic [WordLength-1:0]   rdata0_q, rdata1_q;

  logic grant_valid, grant;
  logic issue, in_burst, beat;
  logic p0_wr_hit, p1_wr_hit, p0_rd_hit, p1_rd_hit;

  sdram_arb_pick u_pick (
    .p0_req      (bus.p0_req),
    .p1_req      (bus.p1_req),
    .owner       (owner_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    beat_cnt_d = beat_cnt_q;
    tmo_d      = tmo_q;
    err_d      = 1'b0;
    issue      = 1'b0;
    in_burst   = 1'b0;
    beat       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_valid && !bus.m_busy) begin
          owner_d = grant;
          rw_d    = grant ? bus.p1_rw : bus.p0_rw;
          addr_d  = grant ? bus.p1_addr : bus.p0_addr;
          state_d = StIssue;
        end
      end
      StIssue: begin
        issue      = 1'b1;
        beat_cnt_d = '0;
        tmo_d      = '0;
        state_d    = StBurst;
      end
      StBurst: begin
        in_burst = 1'b1;
        beat     = rw_q ? bus.m_valid_rd : bus.m_valid_wr;
        tmo_d    = tmo_q + 1'b1;
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == BeatLast) state_d = StDrain;
        end
        if (tmo_q == TmoLast) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StDrain: begin
        tmo_d = tmo_q + 1'b1;
        if (!bus.m_busy) state_d = StIdle;
        if (tmo_q == TmoLast) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign p0_wr_hit = in_burst & ~rw_q & ~owner_q & bus.m_valid_wr;
  assign p1_wr_hit = in_burst & ~rw_q &  owner_q & bus.m_valid_wr;
  assign p0_rd_hit = in_burst &  rw_q & ~owner_q & bus.m_valid_rd;
  assign p1_rd_hit = in_burst &  rw_q &  owner_q & bus.m_valid_rd;

  assign bus.m_enable   = issue;
  assign bus.m_rw       = issue & rw_q;
  assign bus.m_addr     = issue ? addr_q : '0;
  assign bus.m_wdata    = in_burst ? (owner_q ? bus.p1_wdata : bus.p0_wdata) : '0;
  assign bus.p0_ack     = issue & ~owner_q;
  assign bus.p1_ack     = issue &  owner_q;
  assign bus.p0_wr_beat = p0_wr_hit;
  assign bus.p1_wr_beat = p1_wr_hit;
  assign bus.p0_rd_beat = p0_rd_hit;
  assign bus.p1_rd_beat = p1_rd_hit;
  assign bus.p0_rdata   = p0_rd_hit ? bus.m_rdata : rdata0_q;
  assign bus.p1_rdata   = p1_rd_hit ? bus.m_rdata : rdata1_q;
  assign bus.o_owner    = owner_q;
  assign bus.o_err      = err_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= StIdle;
      owner_q    <= 1'b1;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      beat_cnt_q <= beat_cnt_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      if (p0_rd_hit) rdata0_q <= bus.m_rdata;
      if (p1_rd_hit) rdata1_q <= bus.m_rdata;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: grants and beats are predicted at request time.
module tb_sdram_arbiter;

  typedef struct packed {
    logic [1:0]  port;
    logic        rd;
    logic [23:0] addr;
  } req_t;

  typedef struct packed {
    logic [1:0]  port;
    logic        rd;
    logic [15:0] data;
  } beat_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  req_t  exp_req[$];
  beat_t exp_beat[$];

  int          pend[2];
  logic        port_rd[2];
  logic [23:0] port_addr[2];
  int          widx[2];
  int          beat_cnt[4];

  int   cyc = 0;
  bit   start = 1'b0;
  logic model_rw = 1'b0;
  int   quota = 8;
  int   bi = 0;
  bit   gap = 1'b0;
  logic ctl_busy = 1'b0;
  logic ext_busy = 1'b0;
  int   en_cyc = 0;
  int   err_cyc = 0;
  int   n_err = 0;
  int   n_enable = 0;

  int          mon_p;
  req_t        mon_r;
  beat_t       mon_b;
  logic [3:0]  mon_beats;
  logic [15:0] mon_data;

  sdram_arbiter_if #(.AddressWidth(24), .WordLength(16)) bus ();

  sdram_arbiter #(
    .AddressWidth  (24),
    .WordLength    (16),
    .BurstLength   (8),
    .TimeoutCycles (64)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  assign bus.m_busy = ctl_busy | ext_busy;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] wword(input int p, input int i);
    if (p == 0) return 16'h5000 + 16'(i);
    return 16'(32'h1111 * (i + 1));
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_req(input int p, input logic rd, input logic [23:0] a, input int nbeats);
    port_rd[p]   = rd;
    port_addr[p] = a;
    pend[p]++;
    exp_req.push_back({2'(p), rd, a});
    for (int i = 0; i < nbeats; i++)
      exp_beat.push_back({2'(p), rd, rd ? (16'hA000 + 16'(i)) : wword(p, i)});
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_req.size() != 0 || exp_beat.size() != 0 || ctl_busy) && n < 400) begin
      tick();
      n++;
    end
    check_val(tag, 32'(exp_req.size() + exp_beat.size()), 0);
    exp_req.delete();
    exp_beat.delete();
    pend[0] = 0;
    pend[1] = 0;
    repeat (4) tick();
  endtask

  // Requester drive and controller model, updated just after each rising edge.
  initial begin
    bus.p0_req = 1'b0;  bus.p1_req = 1'b0;
    bus.p0_rw = 1'b0;   bus.p1_rw = 1'b0;
    bus.p0_addr = '0;   bus.p1_addr = '0;
    bus.p0_wdata = '0;  bus.p1_wdata = '0;
    bus.m_rdata = '0;   bus.m_valid_wr = 1'b0;  bus.m_valid_rd = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      bus.p0_req   = (pend[0] > 0);
      bus.p1_req   = (pend[1] > 0);
      bus.p0_rw    = port_rd[0];
      bus.p1_rw    = port_rd[1];
      bus.p0_addr  = port_addr[0];
      bus.p1_addr  = port_addr[1];
      bus.p0_wdata = wword(0, widx[0]);
      bus.p1_wdata = wword(1, widx[1]);
      bus.m_valid_wr = 1'b0;
      bus.m_valid_rd = 1'b0;
      if (!RST) begin
        ctl_busy = 1'b0;
        start    = 1'b0;
      end else if (start) begin
        start    = 1'b0;
        ctl_busy = 1'b1;
        bi       = 0;
        gap      = 1'b1;
      end else if (ctl_busy) begin
        if (bi < quota) begin
          if (gap) begin
            // Wrong-direction strobe with junk data; must never be forwarded.
            gap = 1'b0;
            bus.m_rdata = 16'hDEAD;
            if (model_rw) bus.m_valid_wr = 1'b1;
            else          bus.m_valid_rd = 1'b1;
          end else begin
            bus.m_rdata = 16'hA000 + 16'(bi);
            if (model_rw) bus.m_valid_rd = 1'b1;
            else          bus.m_valid_wr = 1'b1;
            bi++;
          end
        end else begin
          ctl_busy = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every ack and beat, mid-cycle.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (bus.m_enable || bus.p0_ack || bus.p1_ack) begin
          mon_p = bus.p1_ack ? 1 : 0;
          check_val("ack_count", 32'(bus.p0_ack) + 32'(bus.p1_ack), 1);
          check_val("en_pulse", 32'(bus.m_enable), 1);
          if (exp_req.size() == 0) begin
            check_val("ack_unexpected", 32'(mon_p), 32'hFFFF_FFFF);
          end else begin
            mon_r = exp_req.pop_front();
            check_val("ack_port", 32'(mon_p), 32'(mon_r.port));
            check_val("en_addr", 32'(bus.m_addr), 32'(mon_r.addr));
            check_val("en_rw", 32'(bus.m_rw), 32'(mon_r.rd));
          end
          if (pend[mon_p] > 0) pend[mon_p]--;
          widx[mon_p] = 0;
          start    = 1'b1;
          model_rw = bus.m_rw;
          en_cyc   = cyc;
          n_enable++;
        end
        mon_beats = {bus.p1_rd_beat, bus.p0_rd_beat, bus.p1_wr_beat, bus.p0_wr_beat};
        for (int k = 0; k < 4; k++) begin
          if (mon_beats[k]) begin
            beat_cnt[k]++;
            mon_data = (k == 2) ? bus.p0_rdata : (k == 3) ? bus.p1_rdata : bus.m_wdata;
            if (exp_beat.size() == 0) begin
              check_val("beat_unexpected", 32'(k), 32'hFFFF_FFFF);
            end else begin
              mon_b = exp_beat.pop_front();
              check_val("beat_src", 32'(k), 32'(mon_b.rd) * 2 + 32'(mon_b.port));
              check_val("beat_data", 32'(mon_data), 32'(mon_b.data));
            end
            if (k < 2) widx[k]++;
          end
        end
        if (bus.o_err) begin
          n_err++;
          err_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    int s0, s1, e0, f, n;
    logic any_out;
    pend[0] = 0;  pend[1] = 0;
    widx[0] = 0;  widx[1] = 0;
    port_rd[0] = 1'b0;  port_rd[1] = 1'b0;
    port_addr[0] = '0;  port_addr[1] = '0;
    for (int k = 0; k < 4; k++) beat_cnt[k] = 0;

    // Reset held with p0 requesting a read.
    RST = 1'b0;
    start_req(0, 1'b1, 24'h000100, 8);
    repeat (3) begin
      tick();
      @(negedge CLK);
      any_out = |{bus.m_enable, bus.m_rw, bus.m_addr, bus.m_wdata, bus.p0_ack, bus.p1_ack,
                  bus.p0_wr_beat, bus.p1_wr_beat, bus.p0_rd_beat, bus.p1_rd_beat,
                  bus.p0_rdata, bus.p1_rdata, bus.o_err};
      check_val("rst_outs_zero", 32'(any_out), 0);
      check_val("rst_owner", 32'(bus.o_owner), 1);
    end
    RST = 1'b1;
    @(negedge CLK);
    check_val("first_ack_p0", 32'(bus.p0_ack), 1);
    wait_idle("reset_read_drained");

    // Single write from p1.
    s0 = beat_cnt[0] + beat_cnt[2] + beat_cnt[3];
    s1 = beat_cnt[1];
    start_req(1, 1'b0, 24'h000000, 8);
    wait_idle("p1_write_drained");
    check_val("p1_wr_beats", 32'(beat_cnt[1] - s1), 8);
    check_val("other_beats", 32'(beat_cnt[0] + beat_cnt[2] + beat_cnt[3] - s0), 0);
    check_val("owner_after_p1", 32'(bus.o_owner), 1);

    // Contention: both ports keep requesting for two bursts each.
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    start_req(0, 1'b1, 24'h010000, 8);
    start_req(0, 1'b1, 24'h010000, 8);
    start_req(1, 1'b0, 24'h020000, 8);
    start_req(1, 1'b0, 24'h020000, 8);
`else
    start_req(0, 1'b1, 24'h010000, 8);
    start_req(1, 1'b0, 24'h020000, 8);
    start_req(0, 1'b1, 24'h010000, 8);
    start_req(1, 1'b0, 24'h020000, 8);
`endif
    wait_idle("contention_drained");
    check_val("owner_after_cont", 32'(bus.o_owner), 1);

    // p0 read: held read data and no p1 read beats.
    s0 = beat_cnt[2];
    s1 = beat_cnt[3];
    start_req(0, 1'b1, 24'h000200, 8);
    wait_idle("p0_read_drained");
    check_val("p0_rd_beats", 32'(beat_cnt[2] - s0), 8);
    check_val("p1_rd_beats", 32'(beat_cnt[3] - s1), 0);
    check_val("p0_rdata_held", 32'(bus.p0_rdata), 32'hA007);
    check_val("owner_after_p0", 32'(bus.o_owner), 0);

    // Timeout: controller stops after 3 beats.
    quota = 3;
    e0 = n_err;
    start_req(0, 1'b1, 24'h000300, 3);
    n = 0;
    while (n_err == e0 && n < 200) begin
      tick();
      n++;
    end
    @(negedge CLK);
    check_val("tmo_err_pulses", 32'(n_err - e0), 1);
    check_val("tmo_err_cycle", 32'(err_cyc - en_cyc), 64);
    wait_idle("tmo_drained");
    quota = 8;
    start_req(1, 1'b0, 24'h000400, 8);
    wait_idle("after_tmo_drained");
    check_val("err_total", 32'(n_err), 1);

    // Busy gating: a request waits while the controller is busy.
    ext_busy = 1'b1;
    e0 = n_enable;
    start_req(1, 1'b0, 24'h000500, 8);
    repeat (20) tick();
    check_val("busy_no_enable", 32'(n_enable - e0), 0);
    ext_busy = 1'b0;
    f = cyc;
    n = 0;
    while (n_enable == e0 && n < 20) begin
      tick();
      n++;
    end
    check_val("busy_enable_cycle", 32'(en_cyc - f), 1);
    wait_idle("busy_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
